// File: rtl/of_stage_hazard_if.sv
// Signal bundle between the OF stage and its neighbours (IF, control unit, GPR file, writeback, EX).
// slave is the OF stage's view; master is the surrounding pipeline's view.
interface of_stage_hazard_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned SCNT_W = 16
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [XLEN-1:0]   if_pc;
  logic              if_ready;

  logic [4:0]        cu_opcode;
  logic              cu_imm;
  logic              cu_is_imm;
  logic              cu_is_st;
  logic              cu_is_ret;
  logic              cu_is_wb;

  logic [3:0]        rd_addr1;
  logic [3:0]        rd_addr2;
  logic [XLEN-1:0]   rd_data1;
  logic [XLEN-1:0]   rd_data2;

  logic              wb_valid;
  logic [3:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_a;
  logic [XLEN-1:0]   ex_b;
  logic [XLEN-1:0]   ex_st_data;
  logic [XLEN-1:0]   ex_branch_pc;
  logic [31:0]       ex_instr;
  logic [3:0]        ex_ctrl;
  logic [SCNT_W-1:0] stall_cnt;

  modport slave (
    input  if_valid, if_instr, if_pc,
    output if_ready,
    output cu_opcode, cu_imm,
    input  cu_is_imm, cu_is_st, cu_is_ret, cu_is_wb,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2,
    input  wb_valid, wb_rd, wb_data,
    input  flush, ex_ready,
    output ex_valid, ex_pc, ex_a, ex_b, ex_st_data, ex_branch_pc, ex_instr, ex_ctrl,
    output stall_cnt
  );

  modport master (
    output if_valid, if_instr, if_pc,
    input  if_ready,
    input  cu_opcode, cu_imm,
    output cu_is_imm, cu_is_st, cu_is_ret, cu_is_wb,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2,
    output wb_valid, wb_rd, wb_data,
    output flush, ex_ready,
    input  ex_valid, ex_pc, ex_a, ex_b, ex_st_data, ex_branch_pc, ex_instr, ex_ctrl,
    input  stall_cnt
  );
endinterface

// File: rtl/of_stage_hazard.sv
// Operand-fetch stage: operand decode with writeback bypass, RAW scoreboard stalls,
// flush, stall counter and a back-pressured OF/EX output register.
module of_stage_hazard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned RA_IDX = 15,
  parameter int unsigned SCNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  of_stage_hazard_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] st;
    logic [XLEN-1:0] br;
    logic [31:0]     instr;
    logic [3:0]      ctrl;
  } ex_pl_t;

  logic [3:0]        rd_f, rs1_f, rs2_f;
  logic [15:0]       imm_f;
  logic [1:0]        mode_f;
  logic [26:0]       off_f;
  logic [3:0]        src1, src2, ex_rd;
  logic              use2, byp1, byp2, haz1, haz2, hazard;
  logic              slot_free, issue, ex_hs;
  logic [XLEN-1:0]   op1, op2, immx, br_tgt;

  logic              ex_valid_q, ex_valid_d;
  ex_pl_t            ex_q, ex_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic busy_at(input logic [NREG-1:0] b, input logic [3:0] a);
    logic hit;
    hit = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (a == 4'(r)) hit = b[r];
    end
    return hit;
  endfunction

  always_comb begin
    rd_f   = bus.if_instr[25:22];
    rs1_f  = bus.if_instr[21:18];
    rs2_f  = bus.if_instr[17:14];
    imm_f  = bus.if_instr[15:0];
    mode_f = bus.if_instr[17:16];
    off_f  = bus.if_instr[26:0];

    src1 = bus.if_valid ? (bus.cu_is_ret ? 4'(RA_IDX) : rs1_f) : '0;
    src2 = bus.if_valid ? (bus.cu_is_st ? rd_f : rs2_f) : '0;
    use2 = bus.cu_is_st | ~bus.cu_is_imm;

    byp1 = bus.wb_valid & (bus.wb_rd == src1);
    byp2 = bus.wb_valid & use2 & (bus.wb_rd == src2);
    op1  = byp1 ? bus.wb_data : bus.rd_data1;
    op2  = byp2 ? bus.wb_data : bus.rd_data2;

    unique case (mode_f)
      2'b00:   immx = {{(XLEN-16){imm_f[15]}}, imm_f};
      2'b10:   immx = {{(XLEN-16){1'b1}}, imm_f};
      default: immx = {{(XLEN-16){1'b0}}, imm_f};
    endcase

    br_tgt = bus.cu_is_ret ? op1
                           : bus.if_pc + {{(XLEN-29){off_f[26]}}, off_f, 2'b00};

    // A producer still sitting in the output register is not yet in the scoreboard.
    ex_rd  = ex_q.instr[25:22];
    haz1   = (busy_at(busy_q, src1) & ~byp1)
           | (ex_valid_q & ex_q.ctrl[0] & (ex_rd == src1));
    haz2   = use2 & ((busy_at(busy_q, src2) & ~byp2)
           | (ex_valid_q & ex_q.ctrl[0] & (ex_rd == src2)));
    hazard = bus.if_valid & (haz1 | haz2);

    slot_free = ~ex_valid_q | bus.ex_ready;
    issue     = bus.if_valid & slot_free & ~hazard & ~bus.flush;
    ex_hs     = ex_valid_q & bus.ex_ready & ex_q.ctrl[0];
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_d        = ex_q;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;

    // Clear first so that a same-cycle set of the same register wins.
    for (int unsigned r = 0; r < NREG; r++) begin
      if (bus.wb_valid && bus.wb_rd == 4'(r)) busy_d[r] = 1'b0;
    end
    for (int unsigned r = 0; r < NREG; r++) begin
      if (ex_hs && ex_rd == 4'(r)) busy_d[r] = 1'b1;
    end

    if (bus.if_valid && slot_free && hazard && !bus.flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + SCNT_W'(1);

    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_d.pc    = bus.if_pc;
      ex_d.a     = op1;
      ex_d.b     = bus.cu_is_imm ? immx : op2;
      ex_d.st    = op2;
      ex_d.br    = br_tgt;
      ex_d.instr = bus.if_instr;
      ex_d.ctrl  = {bus.cu_is_imm, bus.cu_is_st, bus.cu_is_ret, bus.cu_is_wb};
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.if_ready     = slot_free & ~hazard & ~bus.flush;
  assign bus.cu_opcode    = bus.if_instr[31:27];
  assign bus.cu_imm       = bus.if_instr[26];
  assign bus.rd_addr1     = src1;
  assign bus.rd_addr2     = src2;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_a         = ex_q.a;
  assign bus.ex_b         = ex_q.b;
  assign bus.ex_st_data   = ex_q.st;
  assign bus.ex_branch_pc = ex_q.br;
  assign bus.ex_instr     = ex_q.instr;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_of_stage_hazard.sv
// Bench for of_stage_hazard: directed scenarios then random traffic, checked against
// a behavioural model of the stage's rules (register file, busy set, EX slot).
module tb_of_stage_hazard;

  localparam int unsigned SMAX = 65535;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  of_stage_hazard_if #(.XLEN(32), .SCNT_W(16)) bus ();

  of_stage_hazard #(.XLEN(32), .NREG(16), .RA_IDX(15), .SCNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] gpr [16];
  assign bus.rd_data1 = gpr[bus.rd_addr1];
  assign bus.rd_data2 = gpr[bus.rd_addr2];

  typedef struct {
    logic [31:0] pc, a, b, st, br, instr;
    logic [3:0]  ctrl;
  } pl_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference state
  bit          m_v;
  pl_t         m_ex;
  bit          m_busy [16];
  int unsigned m_stall;

  // per-cycle expectations
  logic [3:0]  e_a1, e_a2;
  bit          e_use2, e_haz, e_slot, e_ready, e_issue;
  logic [31:0] e_op1, e_op2;
  pl_t         e_pl;
  logic        seen_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] mode);
    if (mode == 2'b10 || (mode == 2'b00 && imm >= 16'h8000)) return 32'hFFFF_0000 | {16'h0, imm};
    return {16'h0, imm};
  endfunction

  function automatic bit pending(input logic [3:0] s, input bit bypassed);
    return (m_busy[s] && !bypassed) || (m_v && m_ex.ctrl[0] && m_ex.instr[25:22] == s);
  endfunction

  task automatic model_comb();
    int signed soff;
    bit b1, b2;
    e_a1   = !bus.if_valid ? 4'd0 : (bus.cu_is_ret ? 4'd15 : bus.if_instr[21:18]);
    e_a2   = !bus.if_valid ? 4'd0 : (bus.cu_is_st ? bus.if_instr[25:22] : bus.if_instr[17:14]);
    e_use2 = bus.cu_is_st || !bus.cu_is_imm;
    b1     = bus.wb_valid && bus.wb_rd == e_a1;
    b2     = e_use2 && bus.wb_valid && bus.wb_rd == e_a2;
    e_op1  = b1 ? bus.wb_data : gpr[e_a1];
    e_op2  = b2 ? bus.wb_data : gpr[e_a2];
    e_haz  = bus.if_valid && (pending(e_a1, b1) || (e_use2 && pending(e_a2, b2)));
    e_slot = !m_v || bus.ex_ready;
    e_ready = e_slot && !e_haz && !bus.flush;
    e_issue = bus.if_valid && e_ready;
    soff   = $signed({bus.if_instr[26:0], 5'b0}) >>> 5;
    e_pl.pc    = bus.if_pc;
    e_pl.a     = e_op1;
    e_pl.b     = bus.cu_is_imm ? ext(bus.if_instr[15:0], bus.if_instr[17:16]) : e_op2;
    e_pl.st    = e_op2;
    e_pl.br    = bus.cu_is_ret ? e_op1 : bus.if_pc + 32'(soff * 4);
    e_pl.instr = bus.if_instr;
    e_pl.ctrl  = {bus.cu_is_imm, bus.cu_is_st, bus.cu_is_ret, bus.cu_is_wb};
  endtask

  task automatic model_update();
    bit hs;
    if (!rst_n) begin
      m_v = 0;
      m_ex = '{default: '0};
      foreach (m_busy[i]) m_busy[i] = 0;
      m_stall = 0;
    end else begin
      hs = m_v && bus.ex_ready && m_ex.ctrl[0];
      if (bus.wb_valid) m_busy[bus.wb_rd] = 0;
      if (hs) m_busy[m_ex.instr[25:22]] = 1;
      if (bus.if_valid && e_slot && e_haz && !bus.flush && m_stall < SMAX) m_stall++;
      if (bus.flush) m_v = 0;
      else if (e_issue) begin m_v = 1; m_ex = e_pl; end
      else if (bus.ex_ready) m_v = 0;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    model_comb();
    chk("rd_addr1", {28'h0, bus.rd_addr1}, {28'h0, e_a1});
    chk("rd_addr2", {28'h0, bus.rd_addr2}, {28'h0, e_a2});
    chk("cu_opcode", {27'h0, bus.cu_opcode, bus.cu_imm}, {27'h0, bus.if_instr[31:26]});
    if (bus.if_valid) chk("if_ready", {31'h0, bus.if_ready}, {31'h0, e_ready});
    seen_ready = bus.if_ready;
    @(posedge clk);
    model_update();
    #1;
    if (bus.wb_valid) gpr[bus.wb_rd] = bus.wb_data;
    chk("ex_valid", {31'h0, bus.ex_valid}, {31'h0, m_v});
    chk("ex_pc", bus.ex_pc, m_ex.pc);
    chk("ex_a", bus.ex_a, m_ex.a);
    chk("ex_b", bus.ex_b, m_ex.b);
    chk("ex_st_data", bus.ex_st_data, m_ex.st);
    chk("ex_branch_pc", bus.ex_branch_pc, m_ex.br);
    chk("ex_instr", bus.ex_instr, m_ex.instr);
    chk("ex_ctrl", {28'h0, bus.ex_ctrl}, {28'h0, m_ex.ctrl});
    chk("stall_cnt", {16'h0, bus.stall_cnt}, m_stall);
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit imm, input bit st, input bit ret, input bit wb);
    bus.if_valid  = v;
    bus.if_instr  = instr;
    bus.if_pc     = pc;
    bus.cu_is_imm = imm;
    bus.cu_is_st  = st;
    bus.cu_is_ret = ret;
    bus.cu_is_wb  = wb;
  endtask

  function automatic logic [31:0] mk_r(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
    return {5'd2, 1'b0, rd, rs1, rs2, 14'd0};
  endfunction
  function automatic logic [31:0] mk_i(input logic [3:0] rd, input logic [3:0] rs1,
                                       input logic [1:0] mode, input logic [15:0] imm);
    return {5'd3, 1'b1, rd, rs1, mode, imm};
  endfunction
  function automatic logic [31:0] mk_br(input logic [26:0] off);
    return {5'd4, off};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  modes [3];
    logic [31:0] bexp  [3];
    modes = '{2'b00, 2'b01, 2'b10};
    bexp  = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_8001};

    foreach (gpr[i]) gpr[i] = $urandom;
    gpr[2] = 32'd5; gpr[3] = 32'd7; gpr[15] = 32'h40;
    rst_n = 1'b0;
    set_in(0, '0, '0, 0, 0, 0, 0);
    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.flush = 0; bus.ex_ready = 1;
    m_v = 0; m_ex = '{default: '0}; m_stall = 0;
    foreach (m_busy[i]) m_busy[i] = 0;

    step(); step();
    chk("rst_ex_valid", {31'h0, bus.ex_valid}, 32'd0);
    chk("rst_stall", {16'h0, bus.stall_cnt}, 32'd0);
    rst_n = 1'b1;

    // register add r4 = r2 op r3
    set_in(1, mk_r(4, 2, 3), 32'h10, 0, 0, 0, 1);
    step();
    chk("add_valid", {31'h0, bus.ex_valid}, 32'd1);
    chk("add_a", bus.ex_a, 32'd5);
    chk("add_b", bus.ex_b, 32'd7);

    // dependent consumer waits for r4's writeback
    set_in(1, mk_i(5, 4, 2'b01, 16'h0), 32'h14, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("raw_stall_rdy", {31'h0, seen_ready}, 32'd0);
    end
    bus.wb_valid = 1; bus.wb_rd = 4'd4; bus.wb_data = 32'h1234;
    step();
    chk("raw_issue_rdy", {31'h0, seen_ready}, 32'd1);
    chk("raw_bypass_a", bus.ex_a, 32'h1234);
    chk("raw_stall_cnt", {16'h0, bus.stall_cnt}, 32'd3);
    bus.wb_valid = 0;

    for (int i = 0; i < 3; i++) begin
      set_in(1, mk_i(6, 2, modes[i], 16'h8001), 32'h20, 1, 0, 0, 0);
      step();
      chk("imm_ext", bus.ex_b, bexp[i]);
    end

    // back-pressure holds the payload
    set_in(1, mk_r(8, 2, 3), 32'h200, 0, 0, 0, 0);
    step();
    bus.ex_ready = 0;
    set_in(1, mk_r(9, 2, 3), 32'h204, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pc_hold", bus.ex_pc, 32'h200);
      chk("bp_ready", {31'h0, seen_ready}, 32'd0);
      chk("bp_stall_cnt", {16'h0, bus.stall_cnt}, 32'd3);
    end
    bus.ex_ready = 1;
    step();
    chk("bp_release_pc", bus.ex_pc, 32'h204);

    set_in(1, mk_br(27'h7FF_FFFC), 32'h100, 0, 0, 0, 0);
    step();
    chk("branch_pc", bus.ex_branch_pc, 32'hF0);
    set_in(1, mk_br(27'h0), 32'h180, 0, 0, 1, 0);
    step();
    chk("ret_pc", bus.ex_branch_pc, 32'h40);

    // flush while EX is stalled; r7 must not become busy
    set_in(1, mk_r(7, 2, 3), 32'h300, 0, 0, 0, 1);
    step();
    bus.ex_ready = 0; bus.flush = 1;
    set_in(1, mk_r(10, 2, 3), 32'h304, 0, 0, 0, 0);
    step();
    chk("flush_valid", {31'h0, bus.ex_valid}, 32'd0);
    bus.flush = 0; bus.ex_ready = 1;
    set_in(1, mk_i(5, 7, 2'b00, 16'h1), 32'h308, 1, 0, 0, 0);
    step();
    chk("flush_no_busy", {31'h0, seen_ready}, 32'd1);

    // reset mid-stream
    set_in(1, mk_r(11, 2, 3), 32'h400, 0, 0, 0, 1);
    step();
    rst_n = 0; bus.ex_ready = 0;
    step();
    chk("mrst_valid", {31'h0, bus.ex_valid}, 32'd0);
    chk("mrst_pc", bus.ex_pc, 32'd0);
    chk("mrst_a", bus.ex_a, 32'd0);
    chk("mrst_stall", {16'h0, bus.stall_cnt}, 32'd0);
    rst_n = 1; bus.ex_ready = 1;

    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom, $urandom,
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);
      bus.wb_valid = $urandom_range(0, 9) < 3;
      bus.wb_rd    = 4'($urandom_range(0, 15));
      bus.wb_data  = $urandom;
      bus.flush    = $urandom_range(0, 31) == 0;
      bus.ex_ready = $urandom_range(0, 9) < 7;
      rst_n        = $urandom_range(0, 99) != 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/of_stage_hazard.md
# of_stage_hazard

Parametrised operand-fetch stage with a valid/ready handshake, a register scoreboard for RAW hazards, writeback bypass, flush, and an OF/EX output register. It sits between the IF stage and the EX stage, and drives the two GPR read ports. It decodes operands (register or immediate), the branch/return target, and the store-data operand. Compared with the original OF stage it adds back-pressure, hazard stalls, squash and a stall counter.

## Interface
- XLEN, 32, datapath width (≥32); instruction width fixed at 32
- NREG, 16, number of GPRs (2..16); register address fields are 4 bits
- RA_IDX, 15, return-address register index
- SCNT_W, 16, stall counter width
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- if_valid  in  1  IF holds an instruction
- if_instr  in  32  instruction
- if_pc  in  XLEN  instruction PC
- if_ready  out  1  OF accepts the instruction this cycle
- cu_opcode  out  5  if_instr[31:27], to the control unit
- cu_imm  out  1  if_instr[26]
- cu_is_imm, cu_is_st, cu_is_ret, cu_is_wb  in  1 each  control-unit decode for the current instruction (cu_is_wb means it writes rd)
- rd_addr1, rd_addr2  out  4 each  GPR read addresses
- rd_data1, rd_data2  in  XLEN each  GPR read data, combinational
- wb_valid  in  1  writeback this cycle
- wb_rd  in  4  writeback register
- wb_data  in  XLEN  writeback data
- flush  in  1  squash the OF instruction and the output register
- ex_ready  in  1  EX accepts the output register
- ex_valid  out  1  output register valid
- ex_pc, ex_a, ex_b, ex_st_data, ex_branch_pc  out  XLEN each  payload
- ex_instr  out  32  payload
- ex_ctrl  out  4  {is_imm, is_st, is_ret, is_wb}
- stall_cnt  out  SCNT_W  saturating count of hazard-stall cycles

## Operation
- Instruction fields:
  - opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14], imm [15:0], imm mode [17:16], branch offset [26:0].
- Read ports:
  - rd_addr1 = RA_IDX if cu_is_ret, else rs1.
  - rd_addr2 = rd if cu_is_st, else rs2.
  - Both addresses are 0 when if_valid=0.
- Sources used:
  - src1 is always used.
  - src2 is used when cu_is_st or !cu_is_imm.
- Bypass: if wb_valid and wb_rd equals a used source address, the operand comes from wb_data instead of rd_data.
- Immediate extension (immx):
  - Mode 00: sign-extend imm[15].
  - Mode 01: zero-extend.
  - Mode 10: ones-extend.
  - Mode 11: zero-extend.
  - All extensions are to XLEN.
- Operand A = op1.
- Operand B = immx if cu_is_imm, else op2.
- ex_st_data = op2.
- Branch target:
  - ex_branch_pc = op1 if cu_is_ret.
  - Otherwise ex_branch_pc = if_pc + sign-extended ({offset, 2'b00}), modulo 2^XLEN.
- Scoreboard: busy[NREG-1:0].
  - Sets busy[ex rd] on an EX handshake (ex_valid & ex_ready & ex_ctrl.is_wb).
  - Clears busy[wb_rd] on wb_valid.
  - Same register set and cleared in the same cycle: set wins.
  - Addresses ≥ NREG are ignored.
- Hazard, for each used source s, when any of these holds:
  - busy[s] and not bypassed this cycle.
  - ex_valid & ex_ctrl.is_wb & ex rd == s (producer still in the output register or being handed off).
- Slot free: !ex_valid | ex_ready.
- if_ready = slot free & !hazard & !flush.
- Issue = if_valid & if_ready. The output register loads the payload and sets ex_valid=1.
- ex_valid update rule:
  - Clears on flush.
  - Otherwise clears on (ex_ready & !issue).
  - Otherwise holds.
- While ex_valid=1 & ex_ready=0, the payload is held stable.
- stall_cnt increments when if_valid & slot free & hazard & !flush, and saturates at all-ones.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Full throughput (one instruction per cycle) when there is no hazard and ex_ready=1.
- A dependent back-to-back instruction stalls until the producer's wb_valid cycle. It issues in that cycle via the bypass.
- Flush:
  - Takes effect at the next edge: ex_valid=0, no issue that cycle.
  - Scoreboard is unaffected, because squashed entries were never handed to EX.
- Reset (rst_n=0 at an edge):
  - ex_valid=0; all ex_* payload = 0.
  - busy = 0; stall_cnt = 0.
  - Combinational outputs follow their inputs.
  - Reset mid-stall discards the held instruction.
- No combinational path from ex_ready to ex_*; ex_ready affects only if_ready.

## Test plan
- Register add (rs1=2, rs2=3, rd=4, rd_data 5/7), ex_ready=1 -> ex_valid next cycle; ex_a=5, ex_b=7; busy[4] set after handoff.
- Immediate instr with imm=0x8001:
  - mode 00 -> ex_b=0xFFFF8001.
  - mode 01 -> 0x00008001.
  - mode 10 -> 0xFFFF8001.
- Producer rd=4, then consumer rs1=4, wb arrives 3 cycles later with wb_data=0x1234 -> if_ready low for 3 cycles, stall_cnt=3, consumer ex_a=0x1234.
- ex_ready=0 for 4 cycles with ex_valid=1 -> payload stable, if_ready=0, no stall_cnt increment; then ex_ready=1 -> next instruction issues.
- Branch with pc=0x100, offset=-4 -> ex_branch_pc=0xF0. Ret with R15=0x40 -> ex_branch_pc=0x40.
- Flush while ex_valid=1 and ex_ready=0 -> ex_valid=0 next cycle, busy unchanged. rst_n low mid-stream -> all registered outputs are 0 after the edge.
